// File: rtl/bsg_fifo_axi_pkg.sv
// Shared types and constants for the FIFO-to-AXI command scheduler.
package bsg_fifo_axi_pkg;

  // Command opcodes carried in the top three bits of a FIFO entry.
  typedef enum logic [2:0] {
    OP_WRITE = 3'b000,
    OP_READ  = 3'b001
  } opcode_e;

  // A FIFO command. The opcode is kept as raw bits so illegal codes survive.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [22:0] addr23;
  } cmd_t;

  // Address issue FSM states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AW    = 2'd1,
    S_AR    = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // First-error cause codes reported on err_code_o.
  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_OPCODE = 2'd1;
  localparam logic [1:0] ERR_RESP   = 2'd2;
  localparam logic [1:0] ERR_W_SPUR = 2'd3;

endpackage

// File: rtl/bsg_fifo_axi_credit_ctr.sv
// Up/down counter that saturates at 0 and max_p, with at-max and zero flags.
// next_zero_o looks at the value being loaded this cycle so callers can act
// on the counter becoming empty without waiting a cycle.
module bsg_fifo_axi_credit_ctr
  #(parameter int max_p   = 4,
    parameter int width_p = $clog2(max_p + 1))
  (input  logic clk_i,
   input  logic reset_n_i,
   input  logic up_i,
   input  logic down_i,
   output logic at_max_o,
   output logic zero_o,
   output logic next_zero_o);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);
  localparam logic [width_p-1:0] one_lp = width_p'(1);

  logic [width_p-1:0] count_q, count_d;

  // Next count: simultaneous up and down cancel; both ends saturate.
  always_comb begin
    count_d = count_q;
    if (up_i && !down_i) begin
      if (count_q != max_lp) count_d = count_q + one_lp;
      else                   count_d = count_q;
    end else if (down_i && !up_i) begin
      if (count_q != '0) count_d = count_q - one_lp;
      else               count_d = count_q;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) count_q <= '0;
    else            count_q <= count_d;
  end

  assign at_max_o    = (count_q == max_lp);
  assign zero_o      = (count_q == '0);
  assign next_zero_o = (count_d == '0);

endmodule

// File: rtl/bsg_fifo_axi_cmd_sched.sv
// Command scheduler between the DMC command FIFO and the AXI master bridge.
// Pops commands, drives AW/AR, caps outstanding traffic per direction, gates
// the write-data path per burst with WLAST, retires B/R and handles drains.
module bsg_fifo_axi_cmd_sched
  import bsg_fifo_axi_pkg::*;
  #(parameter int axi_id_width_p    = 6,
    parameter int axi_addr_width_p  = 32,
    parameter int axi_burst_len_p   = 2,
    parameter int addr_shift_p      = 5,
    parameter int max_outstanding_p = 4)
  (input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        cmd_v_i,
   input  logic [25:0]                 cmd_data_i,
   output logic                        cmd_yumi_o,
   input  logic                        flush_i,
   output logic                        flush_done_o,
   output logic                        axi_awvalid_o,
   input  logic                        axi_awready_i,
   output logic [axi_id_width_p-1:0]   axi_awid_o,
   output logic [axi_addr_width_p-1:0] axi_awaddr_o,
   output logic                        axi_arvalid_o,
   input  logic                        axi_arready_i,
   output logic [axi_id_width_p-1:0]   axi_arid_o,
   output logic [axi_addr_width_p-1:0] axi_araddr_o,
   input  logic                        w_fire_i,
   output logic                        w_en_o,
   output logic                        axi_wlast_o,
   input  logic                        axi_bvalid_i,
   input  logic [1:0]                  axi_bresp_i,
   output logic                        axi_bready_o,
   input  logic                        r_fire_i,
   input  logic                        axi_rlast_i,
   input  logic [1:0]                  axi_rresp_i,
   output logic                        error_o,
   output logic [1:0]                  err_code_o);

  localparam int beat_width_lp = (axi_burst_len_p > 1) ? $clog2(axi_burst_len_p) : 1;
  localparam logic [beat_width_lp-1:0] beat_last_lp = beat_width_lp'(axi_burst_len_p - 1);
  localparam logic [beat_width_lp-1:0] beat_one_lp  = beat_width_lp'(1);
  localparam logic [axi_id_width_p-1:0] id_one_lp   = axi_id_width_p'(1);

  cmd_t   cmd;
  state_e state_q, state_d;

  logic accept, op_illegal;
  logic aw_hs, ar_hs, b_hs, r_done, w_beat, w_done, resp_err, w_spur;
  logic wr_at_max, wr_zero, wr_next_zero;
  logic rd_at_max, rd_zero, rd_next_zero;
  logic wp_at_max, wp_zero, wp_next_zero;
  logic drained, cnt_unused;

  logic [axi_addr_width_p-1:0] addr_fmt;
  logic [axi_addr_width_p-1:0] aw_addr_q, ar_addr_q;
  logic [axi_id_width_p-1:0]   aw_id_q, ar_id_q, id_q;
  logic [beat_width_lp-1:0]    beat_q;
  logic                        flush_done_q;
  logic                        error_q, error_d;
  logic [1:0]                  err_code_q, err_code_d;

  assign cmd      = cmd_t'(cmd_data_i);
  assign addr_fmt = axi_addr_width_p'(cmd.addr23) << addr_shift_p;

  // B is always accepted; the outstanding cap keeps the slave bounded.
  assign axi_bready_o = 1'b1;

  // Valids come from the FSM state but drop as soon as reset is applied.
  assign axi_awvalid_o = (state_q == S_AW) & reset_n_i;
  assign axi_arvalid_o = (state_q == S_AR) & reset_n_i;
  assign cmd_yumi_o    = cmd_v_i & accept & reset_n_i;

  assign aw_hs  = axi_awvalid_o & axi_awready_i;
  assign ar_hs  = axi_arvalid_o & axi_arready_i;
  assign b_hs   = axi_bvalid_i & axi_bready_o;
  assign r_done = r_fire_i & axi_rlast_i;

  assign w_en_o      = ~wp_zero;
  assign axi_wlast_o = w_en_o & (beat_q == beat_last_lp);
  assign w_beat      = w_fire_i & w_en_o;
  assign w_done      = w_beat & axi_wlast_o;
  assign w_spur      = w_fire_i & ~w_en_o;
  assign resp_err    = (b_hs & (axi_bresp_i != 2'b00)) | (r_fire_i & (axi_rresp_i != 2'b00));

  // Drain completes once every counter will be empty after this cycle.
  assign drained = wr_next_zero & rd_next_zero & wp_next_zero;

  // The settled-zero flags of the address counters have no consumer.
  assign cnt_unused = wr_zero ^ rd_zero;

  bsg_fifo_axi_credit_ctr #(.max_p(max_outstanding_p)) wr_ctr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(aw_hs), .down_i(b_hs),
    .at_max_o(wr_at_max), .zero_o(wr_zero), .next_zero_o(wr_next_zero));

  bsg_fifo_axi_credit_ctr #(.max_p(max_outstanding_p)) rd_ctr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(ar_hs), .down_i(r_done),
    .at_max_o(rd_at_max), .zero_o(rd_zero), .next_zero_o(rd_next_zero));

  bsg_fifo_axi_credit_ctr #(.max_p(max_outstanding_p)) wp_ctr (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .up_i(aw_hs), .down_i(w_done),
    .at_max_o(wp_at_max), .zero_o(wp_zero), .next_zero_o(wp_next_zero));

  // Issue FSM next state and pop decision; blocked commands stay at the head.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    op_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_DRAIN;
        end else if (cmd_v_i) begin
          case (cmd.opcode)
            OP_WRITE: begin
              accept  = ~wr_at_max & ~wp_at_max;
              if (accept) state_d = S_AW;
              else        state_d = S_IDLE;
            end
            OP_READ: begin
              accept  = ~rd_at_max;
              if (accept) state_d = S_AR;
              else        state_d = S_IDLE;
            end
            default: begin
              accept     = 1'b1;
              op_illegal = 1'b1;
              state_d    = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AW: begin
        if (aw_hs) state_d = S_IDLE;
        else       state_d = S_AW;
      end
      S_AR: begin
        if (ar_hs) state_d = S_IDLE;
        else       state_d = S_AR;
      end
      S_DRAIN: begin
        if (drained) state_d = S_IDLE;
        else         state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Capture address/ID at the pop and advance the shared ID on each handshake.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      id_q      <= '0;
    end else begin
      if (cmd_yumi_o && (state_d == S_AW)) begin
        aw_addr_q <= addr_fmt;
        aw_id_q   <= id_q;
      end
      if (cmd_yumi_o && (state_d == S_AR)) begin
        ar_addr_q <= addr_fmt;
        ar_id_q   <= id_q;
      end
      if (aw_hs || ar_hs) id_q <= id_q + id_one_lp;
    end
  end

  assign axi_awaddr_o = aw_addr_q;
  assign axi_awid_o   = aw_id_q;
  assign axi_araddr_o = ar_addr_q;
  assign axi_arid_o   = ar_id_q;

  // Beat position within the current write burst.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)  beat_q <= '0;
    else if (w_done) beat_q <= '0;
    else if (w_beat) beat_q <= beat_q + beat_one_lp;
  end

  // Sticky error; when several causes land together, opcode beats response beats stray W.
  always_comb begin
    error_d    = error_q;
    err_code_d = err_code_q;
    if (!error_q) begin
      if (cmd_yumi_o && op_illegal) begin
        error_d    = 1'b1;
        err_code_d = ERR_OPCODE;
      end else if (resp_err) begin
        error_d    = 1'b1;
        err_code_d = ERR_RESP;
      end else if (w_spur) begin
        error_d    = 1'b1;
        err_code_d = ERR_W_SPUR;
      end else begin
        error_d    = 1'b0;
        err_code_d = ERR_NONE;
      end
    end else begin
      error_d    = 1'b1;
      err_code_d = err_code_q;
    end
  end

  // Error and drain-complete registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      error_q      <= 1'b0;
      err_code_q   <= ERR_NONE;
      flush_done_q <= 1'b0;
    end else begin
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      flush_done_q <= (state_q == S_DRAIN) & drained;
    end
  end

  assign error_o      = error_q;
  assign err_code_o   = err_code_q;
  assign flush_done_o = flush_done_q;

endmodule

// File: tb/tb_bsg_fifo_axi_cmd_sched.sv
// Self-checking bench for bsg_fifo_axi_cmd_sched: directed scenarios with
// literal expectations plus randomized traffic against a transaction model.
module tb_bsg_fifo_axi_cmd_sched;

  localparam int IDW  = 6;
  localparam int AW   = 32;
  localparam int BL   = 2;
  localparam int SH   = 5;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n, cmd_v, flush, awready, arready, w_fire, bvalid, r_fire, rlast;
  logic [25:0]    cmd_data;
  logic [1:0]     bresp, rresp;
  logic           yumi, flush_done, awvalid, arvalid, w_en, wlast, bready, error;
  logic [IDW-1:0] awid, arid;
  logic [AW-1:0]  awaddr, araddr;
  logic [1:0]     err_code;

  bsg_fifo_axi_cmd_sched #(
    .axi_id_width_p(IDW), .axi_addr_width_p(AW), .axi_burst_len_p(BL),
    .addr_shift_p(SH), .max_outstanding_p(MAXO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .cmd_v_i(cmd_v), .cmd_data_i(cmd_data),
    .cmd_yumi_o(yumi), .flush_i(flush), .flush_done_o(flush_done),
    .axi_awvalid_o(awvalid), .axi_awready_i(awready), .axi_awid_o(awid), .axi_awaddr_o(awaddr),
    .axi_arvalid_o(arvalid), .axi_arready_i(arready), .axi_arid_o(arid), .axi_araddr_o(araddr),
    .w_fire_i(w_fire), .w_en_o(w_en), .axi_wlast_o(wlast),
    .axi_bvalid_i(bvalid), .axi_bresp_i(bresp), .axi_bready_o(bready),
    .r_fire_i(r_fire), .axi_rlast_i(rlast), .axi_rresp_i(rresp),
    .error_o(error), .err_code_o(err_code));

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: one address request may be waiting on the bus,
  // plus plain counts of writes, reads and write bursts still owed.
  int          m_req;       // 0 none, 1 write address waiting, 2 read address waiting
  bit          m_drain;
  logic [31:0] m_addr;
  int          m_id, m_next_id;
  int          m_wr, m_rd, m_wp, m_beat;
  bit          m_err, m_fdone;
  int          m_code;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    if (v > MAXO) return MAXO;
    return v;
  endfunction

  task automatic model_reset();
    m_req = 0; m_drain = 0; m_addr = '0; m_id = 0; m_next_id = 0;
    m_wr = 0; m_rd = 0; m_wp = 0; m_beat = 0;
    m_err = 0; m_fdone = 0; m_code = 0;
  endtask

  task automatic idle_inputs();
    cmd_v = 0; cmd_data = '0; flush = 0; awready = 0; arready = 0; w_fire = 0;
    bvalid = 0; bresp = 0; r_fire = 0; rlast = 0; rresp = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return 1 after the rise.
  task automatic cyc();
    logic [2:0] op;
    bit yumi_e, awv_e, arv_e, wen_e, wlast_e, idle;
    bit aw_hs, ar_hs, w_ok, w_done;
    @(negedge clk);
    op      = cmd_data[25:23];
    idle    = (m_req == 0) && !m_drain;
    awv_e   = reset_n && (m_req == 1);
    arv_e   = reset_n && (m_req == 2);
    yumi_e  = reset_n && idle && !flush && cmd_v &&
              ((op == 3'd0) ? (m_wr < MAXO) : (op == 3'd1) ? (m_rd < MAXO) : 1'b1);
    wen_e   = (m_wp != 0);
    wlast_e = wen_e && (m_beat == BL - 1);
    chk("cmd_yumi", yumi, yumi_e);
    chk("awvalid", awvalid, awv_e);
    chk("arvalid", arvalid, arv_e);
    if (awv_e) begin
      chk("awaddr", awaddr, m_addr);
      chk("awid", awid, m_id);
    end
    if (arv_e) begin
      chk("araddr", araddr, m_addr);
      chk("arid", arid, m_id);
    end
    if (reset_n) begin
      chk("w_en", w_en, wen_e);
      chk("wlast", wlast, wlast_e);
      chk("bready", bready, 1'b1);
      chk("flush_done", flush_done, m_fdone);
      chk("error", error, m_err);
      chk("err_code", err_code, m_code);
    end
    if (!reset_n) begin
      model_reset();
    end else begin
      aw_hs  = awv_e && awready;
      ar_hs  = arv_e && arready;
      w_ok   = w_fire && wen_e;
      w_done = w_ok && wlast_e;
      if (!m_err) begin
        if (yumi_e && op > 3'd1) begin m_err = 1; m_code = 1; end
        else if ((bvalid && bresp != 0) || (r_fire && rresp != 0)) begin m_err = 1; m_code = 2; end
        else if (w_fire && !wen_e) begin m_err = 1; m_code = 3; end
      end
      m_wr   = clampc(m_wr + int'(aw_hs) - int'(bvalid));
      m_rd   = clampc(m_rd + int'(ar_hs) - int'(r_fire && rlast));
      m_wp   = clampc(m_wp + int'(aw_hs) - int'(w_done));
      m_beat = w_done ? 0 : (w_ok ? m_beat + 1 : m_beat);
      m_fdone = m_drain && (m_wr == 0) && (m_rd == 0) && (m_wp == 0);
      if (m_drain) begin
        if (m_fdone) m_drain = 0;
      end else if (m_req != 0) begin
        if (aw_hs || ar_hs) begin
          m_req = 0;
          m_next_id = (m_next_id + 1) % (1 << IDW);
        end
      end else if (flush) begin
        m_drain = 1;
      end else if (yumi_e && op <= 3'd1) begin
        m_req  = (op == 3'd0) ? 1 : 2;
        m_addr = 32'(cmd_data[22:0]) << SH;
        m_id   = m_next_id;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    cyc();
    cyc();
    reset_n = 1;
  endtask

  task automatic rand_inputs();
    logic [2:0] op;
    cmd_v    = 1'($urandom_range(0, 1));
    op       = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
    cmd_data = {op, 23'($urandom)};
    flush    = ($urandom_range(0, 39) == 0);
    awready  = ($urandom_range(0, 9) < 7);
    arready  = ($urandom_range(0, 9) < 7);
    w_fire   = (m_wp != 0) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 63) == 0);
    bvalid   = ((m_wr - m_wp) > 0) && ($urandom_range(0, 1) == 1);
    bresp    = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    r_fire   = (m_rd > 0) && ($urandom_range(0, 1) == 1);
    rlast    = 1'($urandom_range(0, 1));
    rresp    = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
  endtask

  initial begin
    int n_ar;
    bit found;
    model_reset();
    idle_inputs();
    reset_n = 0;
    do_reset();

    // Reset state.
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_awaddr", awaddr, 32'h0);
    chk("rst_awid", awid, 6'd0);
    chk("rst_w_en", w_en, 1'b0);
    chk("rst_bready", bready, 1'b1);
    chk("rst_error", error, 1'b0);
    chk("rst_code", err_code, 2'd0);

    // Single write at 0x10 through its burst and response, then an empty drain.
    cmd_v = 1; cmd_data = {3'b000, 23'h10}; awready = 1;
    #1 chk("wr_pop", yumi, 1'b1);
    cyc();
    cmd_v = 0;
    chk("wr_awvalid", awvalid, 1'b1);
    chk("wr_awaddr", awaddr, 32'h200);
    chk("wr_awid", awid, 6'd0);
    cyc();
    chk("wr_w_en", w_en, 1'b1);
    chk("wr_beat0_wlast", wlast, 1'b0);
    w_fire = 1;
    cyc();
    chk("wr_beat1_wlast", wlast, 1'b1);
    cyc();
    w_fire = 0;
    chk("wr_w_en_off", w_en, 1'b0);
    bvalid = 1;
    cyc();
    bvalid = 0; flush = 1;
    cyc();
    flush = 0;
    cyc();
    chk("wr_empty_flush_done", flush_done, 1'b1);
    cyc();
    chk("wr_flush_done_once", flush_done, 1'b0);

    // Five back-to-back reads against a cap of four.
    do_reset();
    cmd_v = 1; cmd_data = {3'b001, 23'h3}; arready = 1;
    n_ar = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (arvalid) begin
        chk("rd_id_seq", arid, 6'(n_ar));
        n_ar++;
      end
    end
    chk("rd_cap_count", n_ar, 4);
    #1 chk("rd_cap_blocks_pop", yumi, 1'b0);
    r_fire = 1; rlast = 1;
    cyc();
    r_fire = 0; rlast = 0;
    found = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (arvalid && !found) begin
        found = 1;
        chk("rd5_arid", arid, 6'd4);
        chk("rd5_araddr", araddr, 32'h60);
      end
    end
    chk("rd5_issued", found, 1'b1);
    cmd_v = 0;

    // AW stalled for five cycles with another command waiting.
    do_reset();
    cmd_v = 1; cmd_data = {3'b000, 23'h7}; awready = 0;
    cyc();
    cmd_data = {3'b000, 23'h8};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_awvalid", awvalid, 1'b1);
      chk("stall_awaddr", awaddr, 32'hE0);
      chk("stall_awid", awid, 6'd0);
      chk("stall_no_pop", yumi, 1'b0);
      cyc();
    end
    cmd_v = 0; awready = 1;
    cyc();
    cyc();

    // Illegal opcode, then a later bad response keeps the first cause.
    do_reset();
    cmd_v = 1; cmd_data = {3'b111, 23'h5};
    #1 chk("ill_pop", yumi, 1'b1);
    cyc();
    cmd_v = 0;
    chk("ill_error", error, 1'b1);
    chk("ill_code", err_code, 2'd1);
    chk("ill_no_aw", awvalid, 1'b0);
    chk("ill_no_ar", arvalid, 1'b0);
    bvalid = 1; bresp = 2'd2;
    cyc();
    bvalid = 0; bresp = 0;
    chk("ill_code_kept", err_code, 2'd1);

    // Two writes in flight, then a flush.
    do_reset();
    cmd_v = 1; cmd_data = {3'b000, 23'h1}; awready = 1;
    cyc(); cyc(); cyc();
    cmd_v = 0;
    cyc();
    flush = 1; cmd_v = 1;
    cyc();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("drain_no_pop", yumi, 1'b0);
      cyc();
    end
    cmd_v = 0; w_fire = 1;
    for (int i = 0; i < 4; i++) cyc();
    w_fire = 0;
    chk("drain_not_done", flush_done, 1'b0);
    bvalid = 1;
    cyc();
    chk("drain_wait_b", flush_done, 1'b0);
    cyc();
    bvalid = 0;
    chk("drain_done", flush_done, 1'b1);
    cyc();
    chk("drain_done_pulse", flush_done, 1'b0);

    // Reset while AW is stalled.
    do_reset();
    cmd_v = 1; cmd_data = {3'b000, 23'h2}; awready = 0;
    cyc();
    cmd_v = 0;
    chk("mid_awvalid", awvalid, 1'b1);
    reset_n = 0;
    #1 chk("mid_awvalid_drop", awvalid, 1'b0);
    cyc();
    chk("mid_awvalid_after", awvalid, 1'b0);
    chk("mid_w_en", w_en, 1'b0);
    chk("mid_bready", bready, 1'b1);
    reset_n = 1;
    cyc();

    // Randomized traffic against the model.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        rand_inputs();
        cyc();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
